// File: rtl/spi_slave_param.sv
// Parametrised SPI slave (CPOL/CPHA modes, DATA_W-bit words, double-buffered TX).
// Define SPI_SLAVE_LOOPBACK_EN to echo the last received word on a TX underrun.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 1,
  parameter int CPHA        = 1,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              SPI_SCLK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic CPOL_B = CPOL[0];

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e            state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic              sclk_prev_q, cs_prev_q;
  logic [DATA_W-1:0] hold_q, tx_shift_q, rx_shift_q, rx_data_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              tx_ready_q, miso_q, rx_valid_q, tx_underrun_q, frame_abort_q, busy_q;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // Synchronisers are cleared to 0, so a CS already low at reset release shows no falling edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic              sclk_s, cs_s, mosi_s;
  logic              cs_fall, cs_rise, sclk_edge, lead_edge, trail_edge;
  logic              sample_edge, shift_edge, word_done, do_load, miso_ld;
  logic [DATA_W-1:0] rx_next, underrun_word, load_word, tx_shift_ld;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;
  assign sclk_edge   = sclk_s ^ sclk_prev_q;
  assign lead_edge   = sclk_edge & (sclk_s != CPOL_B);
  assign trail_edge  = sclk_edge & (sclk_s == CPOL_B);
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign rx_next     = (MSB_FIRST != 0) ? {rx_shift_q[DATA_W-2:0], mosi_s}
                                        : {mosi_s, rx_shift_q[DATA_W-1:1]};
  assign word_done   = sample_edge && (bit_cnt_q == LAST_BIT);
  assign do_load     = ((state_q == IDLE) && cs_fall) ||
                       ((state_q == ACTIVE) && !cs_rise && word_done);

`ifdef SPI_SLAVE_LOOPBACK_EN
  assign underrun_word = word_done ? rx_next : rx_data_q;
`else
  assign underrun_word = '0;
`endif

  // An empty holding register (tx_ready high) means the load sees an underrun.
  assign load_word   = tx_ready_q ? underrun_word : hold_q;
  assign tx_shift_ld = (CPHA == 0) ? advance(load_word) : load_word;
  assign miso_ld     = (CPHA == 0) ? first_bit(load_word) : miso_q;

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      tx_ready_q    <= 1'b1;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;

      if (do_load && !tx_ready_q) begin
        tx_ready_q <= 1'b1;
      end else if (tx_valid && tx_ready_q) begin
        hold_q     <= tx_data;
        tx_ready_q <= 1'b0;
      end
      if (do_load && tx_ready_q) tx_underrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= ACTIVE;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= tx_shift_ld;
            miso_q     <= miso_ld;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
            if (bit_cnt_q != '0) frame_abort_q <= 1'b1;
          end else if (sample_edge) begin
            rx_shift_q <= rx_next;
            if (word_done) begin
              bit_cnt_q  <= '0;
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              tx_shift_q <= tx_shift_ld;
              miso_q     <= miso_ld;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (shift_edge) begin
            // With CPHA=0 the first bit of a word is already out after its load.
            if ((CPHA != 0) || (bit_cnt_q != '0)) begin
              miso_q     <= first_bit(tx_shift_q);
              tx_shift_q <= advance(tx_shift_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SPI_MISO    = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: four instances cover modes 0..3, 8/16-bit words, MSB/LSB first.
module tb_spi_slave_param;

`ifdef SPI_SLAVE_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif
  localparam int H = 8;  // SCLK half period in clk_in cycles

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  sclk, cs, mosi, miso, tx_valid, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
  logic [15:0] txd [4];
  logic [7:0]  rx_d0, rx_d1;
  logic [15:0] rx_d2, rx_d3;

  int cfg_cpol [4] = '{1, 0, 0, 1};
  int cfg_cpha [4] = '{1, 0, 1, 0};
  int cfg_w    [4] = '{8, 8, 16, 16};
  int cfg_msb  [4] = '{1, 1, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;
  int rxv_cnt [4] = '{0, 0, 0, 0};
  int und_cnt [4] = '{0, 0, 0, 0};
  int abt_cnt [4] = '{0, 0, 0, 0};

  always #5 clk_in = ~clk_in;

  spi_slave_param #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
    .clk_in(clk_in), .rst(rst), .SPI_SCLK(sclk[0]), .SPI_CS(cs[0]), .SPI_MOSI(mosi[0]),
    .SPI_MISO(miso[0]), .tx_data(txd[0][7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_d0), .rx_valid(rx_valid[0]), .tx_underrun(tx_underrun[0]),
    .frame_abort(frame_abort[0]), .busy(busy[0]));

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
    .clk_in(clk_in), .rst(rst), .SPI_SCLK(sclk[1]), .SPI_CS(cs[1]), .SPI_MOSI(mosi[1]),
    .SPI_MISO(miso[1]), .tx_data(txd[1][7:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_d1), .rx_valid(rx_valid[1]), .tx_underrun(tx_underrun[1]),
    .frame_abort(frame_abort[1]), .busy(busy[1]));

  spi_slave_param #(.DATA_W(16), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(3)) u_m1_w16 (
    .clk_in(clk_in), .rst(rst), .SPI_SCLK(sclk[2]), .SPI_CS(cs[2]), .SPI_MOSI(mosi[2]),
    .SPI_MISO(miso[2]), .tx_data(txd[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .rx_data(rx_d2), .rx_valid(rx_valid[2]), .tx_underrun(tx_underrun[2]),
    .frame_abort(frame_abort[2]), .busy(busy[2]));

  spi_slave_param #(.DATA_W(16), .CPOL(1), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_m2_w16 (
    .clk_in(clk_in), .rst(rst), .SPI_SCLK(sclk[3]), .SPI_CS(cs[3]), .SPI_MOSI(mosi[3]),
    .SPI_MISO(miso[3]), .tx_data(txd[3]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
    .rx_data(rx_d3), .rx_valid(rx_valid[3]), .tx_underrun(tx_underrun[3]),
    .frame_abort(frame_abort[3]), .busy(busy[3]));

  // Pulse counters count high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk_in) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i])    rxv_cnt[i]++;
      if (tx_underrun[i]) und_cnt[i]++;
      if (frame_abort[i]) abt_cnt[i]++;
    end
  end

  function automatic logic [15:0] rxd(input int idx);
    case (idx)
      0:       return {8'h00, rx_d0};
      1:       return {8'h00, rx_d1};
      2:       return rx_d2;
      default: return rx_d3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push(input int idx, input logic [15:0] data);
    check($sformatf("tx_ready_before_push[%0d]", idx), 32'(tx_ready[idx]), 32'h1);
    txd[idx] = data;
    tx_valid[idx] = 1'b1;
    wait_clk(1);
    tx_valid[idx] = 1'b0;
    check($sformatf("tx_ready_after_push[%0d]", idx), 32'(tx_ready[idx]), 32'h0);
  endtask

  task automatic cs_fall(input int idx);
    cs[idx] = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_rise(input int idx);
    wait_clk(H);
    cs[idx] = 1'b1;
    wait_clk(H);
  endtask

  // Master side: drive nbits of word, capture MISO at each sample edge into the same bit position.
  task automatic spi_bits(input int idx, input logic [15:0] word, input int nbits,
                          output logic [15:0] got);
    logic cp;
    int   pos;
    cp  = 1'(cfg_cpol[idx]);
    got = '0;
    for (int b = 0; b < nbits; b++) begin
      pos = (cfg_msb[idx] != 0) ? cfg_w[idx] - 1 - b : b;
      if (cfg_cpha[idx] == 0) begin
        mosi[idx] = word[pos];
        wait_clk(H);
        sclk[idx] = ~cp;
        got[pos]  = miso[idx];
        wait_clk(H);
        sclk[idx] = cp;
      end else begin
        sclk[idx] = ~cp;
        mosi[idx] = word[pos];
        wait_clk(H);
        sclk[idx] = cp;
        got[pos]  = miso[idx];
        wait_clk(H);
      end
    end
  endtask

  initial begin
    logic [15:0] g0, g1, g2;
    int rxv0, und0, abt0;

    sclk = 4'b1001;
    cs = 4'hF;
    mosi = 4'h0;
    tx_valid = 4'h0;
    for (int i = 0; i < 4; i++) txd[i] = '0;
    rst = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_miso[%0d]", i), 32'(miso[i]), 32'h0);
      check($sformatf("reset_tx_ready[%0d]", i), 32'(tx_ready[i]), 32'h1);
      check($sformatf("reset_rx_data[%0d]", i), 32'(rxd(i)), 32'h0);
      check($sformatf("reset_busy[%0d]", i), 32'(busy[i]), 32'h0);
    end

    // Mode 3: preloaded 0xA5 out, 0x3C in.
    push(0, 16'h00A5);
    rxv0 = rxv_cnt[0]; und0 = und_cnt[0];
    cs_fall(0);
    check("m3_busy_in_frame", 32'(busy[0]), 32'h1);
    spi_bits(0, 16'h003C, 8, g0);
    cs_rise(0);
    check("m3_miso_word", 32'(g0), 32'hA5);
    check("m3_rx_data", 32'(rxd(0)), 32'h3C);
    check("m3_rx_valid_count", 32'(rxv_cnt[0] - rxv0), 32'd1);
    // The reload after the word finds the holding register empty.
    check("m3_underrun_count", 32'(und_cnt[0] - und0), 32'd1);
    check("m3_busy_after", 32'(busy[0]), 32'h0);
    check("m3_miso_idle", 32'(miso[0]), 32'h0);
    check("m3_tx_ready_after", 32'(tx_ready[0]), 32'h1);

    // Mode 0: three-word frame; third word underruns, 0xEE refills during word 3.
    push(1, 16'h00C1);
    rxv0 = rxv_cnt[1]; und0 = und_cnt[1]; abt0 = abt_cnt[1];
    cs_fall(1);
    fork
      spi_bits(1, 16'h0011, 8, g0);
      begin wait_clk(30); push(1, 16'h00C2); end
    join
    spi_bits(1, 16'h0022, 8, g1);
    fork
      spi_bits(1, 16'h0033, 8, g2);
      begin wait_clk(30); push(1, 16'h00EE); end
    join
    cs_rise(1);
    check("m0_miso_word1", 32'(g0), 32'hC1);
    check("m0_miso_word2", 32'(g1), 32'hC2);
    check("m0_miso_word3", 32'(g2), LOOPBACK ? 32'h22 : 32'h00);
    check("m0_rx_data", 32'(rxd(1)), 32'h33);
    check("m0_rx_valid_count", 32'(rxv_cnt[1] - rxv0), 32'd3);
    check("m0_underrun_count", 32'(und_cnt[1] - und0), 32'd1);
    check("m0_no_abort", 32'(abt_cnt[1] - abt0), 32'd0);

    // Abort after 5 bits, then a clean frame.
    rxv0 = rxv_cnt[1]; abt0 = abt_cnt[1];
    cs_fall(1);
    spi_bits(1, 16'h00FF, 5, g0);
    cs_rise(1);
    check("abort_pulse_count", 32'(abt_cnt[1] - abt0), 32'd1);
    check("abort_no_rx_valid", 32'(rxv_cnt[1] - rxv0), 32'd0);
    check("abort_rx_data_kept", 32'(rxd(1)), 32'h33);
    check("abort_busy", 32'(busy[1]), 32'h0);
    push(1, 16'h0069);
    rxv0 = rxv_cnt[1]; abt0 = abt_cnt[1];
    cs_fall(1);
    spi_bits(1, 16'h0096, 8, g0);
    cs_rise(1);
    check("post_abort_rx_data", 32'(rxd(1)), 32'h96);
    check("post_abort_miso", 32'(g0), 32'h69);
    check("post_abort_rx_valid", 32'(rxv_cnt[1] - rxv0), 32'd1);
    check("post_abort_no_abort", 32'(abt_cnt[1] - abt0), 32'd0);

    // 16-bit LSB-first words in modes 1 and 2.
    for (int i = 2; i < 4; i++) begin
      push(i, 16'h1234);
      rxv0 = rxv_cnt[i];
      cs_fall(i);
      spi_bits(i, 16'h8001, 16, g0);
      cs_rise(i);
      check($sformatf("w16_rx_data[%0d]", i), 32'(rxd(i)), 32'h8001);
      check($sformatf("w16_miso_word[%0d]", i), 32'(g0), 32'h1234);
      check($sformatf("w16_rx_valid_count[%0d]", i), 32'(rxv_cnt[i] - rxv0), 32'd1);
    end

    // Reset mid-word with CS held low.
    push(0, 16'h0077);
    cs_fall(0);
    spi_bits(0, 16'h00FF, 3, g0);
    rst = 1'b1;
    wait_clk(2);
    check("rst_miso", 32'(miso[0]), 32'h0);
    check("rst_tx_ready", 32'(tx_ready[0]), 32'h1);
    check("rst_rx_data", 32'(rxd(0)), 32'h0);
    check("rst_rx_valid", 32'(rx_valid[0]), 32'h0);
    check("rst_tx_underrun", 32'(tx_underrun[0]), 32'h0);
    check("rst_frame_abort", 32'(frame_abort[0]), 32'h0);
    check("rst_busy", 32'(busy[0]), 32'h0);
    check("rst_other_rx_data", 32'(rxd(1)), 32'h0);
    rst = 1'b0;
    rxv0 = rxv_cnt[0]; und0 = und_cnt[0];
    wait_clk(H);
    spi_bits(0, 16'h00AA, 8, g0);
    wait_clk(H);
    check("cs_low_at_release_busy", 32'(busy[0]), 32'h0);
    check("cs_low_at_release_rx_valid", 32'(rxv_cnt[0] - rxv0), 32'd0);
    check("cs_low_at_release_underrun", 32'(und_cnt[0] - und0), 32'd0);
    check("cs_low_at_release_rx_data", 32'(rxd(0)), 32'h0);
    check("cs_low_at_release_miso", 32'(miso[0]), 32'h0);
    cs[0] = 1'b1;
    wait_clk(2 * H);

    // Empty TX after a 0x5A frame: echo with loopback, zeros without.
    cs_fall(0);
    spi_bits(0, 16'h005A, 8, g0);
    cs_rise(0);
    check("echo_first_rx_data", 32'(rxd(0)), 32'h5A);
    und0 = und_cnt[0];
    cs_fall(0);
    check("echo_underrun_pulse", 32'(und_cnt[0] - und0), 32'd1);
    spi_bits(0, 16'h00C3, 8, g1);
    cs_rise(0);
    check("echo_miso_word", 32'(g1), LOOPBACK ? 32'h5A : 32'h00);
    check("echo_second_rx_data", 32'(rxd(0)), 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
